// File: rtl/pc_fetch_sequencer.sv
// Sequencer for the program addresser: opcode fetch, PC increment, and two-byte
// absolute jumps / conditional branches. Every output is registered.
module pc_fetch_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       mem_rdy,
  input  logic [7:0] mem_data,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_type,
  input  logic       cond,
  output logic       cmd_ready,
  output logic [7:0] opcode,
  output logic       opcode_valid,
  output logic [4:0] ctrl_signals,
  output logic [7:0] pc_data,
  output logic       error,
  output logic [3:0] state_dbg
);

  // Command handshake: a command is taken on a rising clock edge where
  // cmd_valid and cmd_ready are both high; the decoder holds cmd_type/cond
  // stable while cmd_valid is high and ready is low.

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  localparam logic [4:0] CTRL_SEL = 5'b00001;
  localparam logic [4:0] CTRL_PCH = 5'b00010;
  localparam logic [4:0] CTRL_PCL = 5'b00100;
  localparam logic [4:0] CTRL_IR  = 5'b01000;
  localparam logic [4:0] CTRL_RD  = 5'b10000;

  localparam logic [1:0] CMD_NEXT   = 2'b00;
  localparam logic [1:0] CMD_JUMP   = 2'b01;
  localparam logic [1:0] CMD_BRANCH = 2'b10;
  localparam logic [1:0] CMD_HALT   = 2'b11;

  typedef enum logic [3:0] {
    IDLE, FETCH, INC, DISPATCH, OP_RD, OP_INC, LOAD_LO, LOAD_HI, HALT
  } state_t;

  state_t     state, state_n;
  logic [7:0] lo, lo_n, hi, hi_n;
  logic [7:0] to_cnt, to_cnt_n, to_cnt_inc;
  logic       take, take_n;
  logic       op_idx, op_idx_n;
  logic       run_low, run_low_n;
  logic [7:0] opcode_n, pc_data_n;
  logic [4:0] ctrl_n;
  logic       cmd_ready_n, opcode_valid_n, error_n;
  logic       mem_rd, accept;

  assign mem_rd     = (state == FETCH) || (state == OP_RD);
  assign accept     = cmd_valid & cmd_ready;
  assign to_cnt_inc = to_cnt + 8'd1;
  assign state_dbg  = state;

  always_comb begin
    state_n   = state;
    lo_n      = lo;
    hi_n      = hi;
    take_n    = take;
    op_idx_n  = op_idx;
    run_low_n = run_low;
    opcode_n  = opcode;
    error_n   = error;
    to_cnt_n  = 8'd0;

    case (state)
      IDLE: if (run) state_n = FETCH;
      FETCH: begin
        if (mem_rdy) begin
          opcode_n = mem_data;
          state_n  = INC;
        end
      end
      INC: state_n = DISPATCH;
      DISPATCH: begin
        if (accept) begin
          op_idx_n = 1'b0;
          case (cmd_type)
            CMD_NEXT: state_n = FETCH;
            CMD_JUMP: begin
              take_n  = 1'b1;
              state_n = OP_RD;
            end
            CMD_BRANCH: begin
              take_n  = cond;
              state_n = OP_RD;
            end
            CMD_HALT: begin
              run_low_n = 1'b0;
              state_n   = HALT;
            end
            default: state_n = DISPATCH;
          endcase
        end
      end
      OP_RD: begin
        if (mem_rdy) begin
          // An untaken branch still consumes both operand bytes but keeps neither.
          if (take && !op_idx) lo_n = mem_data;
          if (take && op_idx)  hi_n = mem_data;
          state_n = OP_INC;
        end
      end
      OP_INC: begin
        if (!op_idx) begin
          op_idx_n = 1'b1;
          state_n  = OP_RD;
        end else begin
          state_n = take ? LOAD_LO : FETCH;
        end
      end
      LOAD_LO: state_n = LOAD_HI;
      LOAD_HI: state_n = FETCH;
      HALT: begin
        if (!run)        run_low_n = 1'b1;
        else if (run_low) state_n  = FETCH;
      end
      default: state_n = IDLE;
    endcase

    // A memory read that stalls too long overrides whatever the FSM chose.
    if (mem_rd && !mem_rdy) begin
      if (to_cnt_inc >= TIMEOUT_W) begin
        error_n   = 1'b1;
        run_low_n = 1'b0;
        state_n   = HALT;
      end else begin
        to_cnt_n = to_cnt_inc;
      end
    end

    ctrl_n         = 5'b00000;
    pc_data_n      = pc_data;
    cmd_ready_n    = 1'b0;
    opcode_valid_n = 1'b0;
    case (state_n)
      FETCH, OP_RD: ctrl_n = CTRL_RD;
      INC: begin
        ctrl_n         = CTRL_PCL | CTRL_PCH | CTRL_IR;
        opcode_valid_n = 1'b1;
      end
      OP_INC:   ctrl_n = CTRL_PCL | CTRL_PCH;
      LOAD_LO: begin
        ctrl_n    = CTRL_SEL | CTRL_PCL;
        pc_data_n = lo;
      end
      LOAD_HI: begin
        ctrl_n    = CTRL_SEL | CTRL_PCH;
        pc_data_n = hi;
      end
      DISPATCH: cmd_ready_n = run;
      default:  ctrl_n = 5'b00000;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lo           <= 8'd0;
      hi           <= 8'd0;
      to_cnt       <= 8'd0;
      take         <= 1'b0;
      op_idx       <= 1'b0;
      run_low      <= 1'b0;
      opcode       <= 8'd0;
      pc_data      <= 8'd0;
      ctrl_signals <= 5'd0;
      cmd_ready    <= 1'b0;
      opcode_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_n;
      lo           <= lo_n;
      hi           <= hi_n;
      to_cnt       <= to_cnt_n;
      take         <= take_n;
      op_idx       <= op_idx_n;
      run_low      <= run_low_n;
      opcode       <= opcode_n;
      pc_data      <= pc_data_n;
      ctrl_signals <= ctrl_n;
      cmd_ready    <= cmd_ready_n;
      opcode_valid <= opcode_valid_n;
      error        <= error_n;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: a PC/memory environment model plus an
// instruction-level interpreter that predicts fetched opcodes and PC values.
module tb_pc_fetch_sequencer;

  localparam int TIMEOUT = 4;
  localparam logic [1:0] C_NEXT   = 2'b00;
  localparam logic [1:0] C_JUMP   = 2'b01;
  localparam logic [1:0] C_BRANCH = 2'b10;
  localparam logic [1:0] C_HALT   = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       mem_rdy = 1'b0;
  logic [7:0] mem_data = 8'd0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'b00;
  logic       cond = 1'b0;
  logic       cmd_ready;
  logic [7:0] opcode;
  logic       opcode_valid;
  logic [4:0] ctrl_signals;
  logic [7:0] pc_data;
  logic       error;
  logic [3:0] state_dbg;

  pc_fetch_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .run(run), .mem_rdy(mem_rdy),
    .mem_data(mem_data), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cond(cond), .cmd_ready(cmd_ready), .opcode(opcode),
    .opcode_valid(opcode_valid), .ctrl_signals(ctrl_signals),
    .pc_data(pc_data), .error(error), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0]  mem [256];
  logic [15:0] pc_model;
  logic [15:0] exp_pc;
  int          delay_mode;
  bit          mem_stall;
  int          wait_left;
  int          n_fetch_inc, n_op_inc, n_valid, n_memrd, n_load;
  logic [4:0]  load_ctrl [2];
  logic [7:0]  load_data [2];
  logic [4:0]  post_load_ctrl;
  bit          last_load;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_delay();
    if (delay_mode >= 0) return delay_mode;
    return int'($urandom_range(0, 3));
  endfunction

  // Environment: program memory with random latency and the PC addresser.
  always @(negedge clock) begin
    if (reset) begin
      pc_model  = 16'h0000;
      mem_rdy   = 1'b0;
      wait_left = pick_delay();
      last_load = 1'b0;
    end else begin
      check_eq("rd_sel_exclusive", 16'(ctrl_signals[4] & ctrl_signals[0]), 16'h0);
      check_eq("valid_only_in_inc", 16'(opcode_valid), 16'(ctrl_signals == 5'b01110));
      if (ctrl_signals[4]) n_memrd++;
      if (opcode_valid) n_valid++;
      if (ctrl_signals == 5'b01110) n_fetch_inc++;
      if (ctrl_signals == 5'b00110) n_op_inc++;
      if (last_load && !ctrl_signals[0]) post_load_ctrl = ctrl_signals;
      if (ctrl_signals[0]) begin
        if (n_load < 2) begin
          load_ctrl[n_load] = ctrl_signals;
          load_data[n_load] = pc_data;
        end
        n_load++;
      end
      last_load = ctrl_signals[0];

      if (ctrl_signals[4] && !mem_stall && wait_left == 0) begin
        mem_rdy   = 1'b1;
        mem_data  = mem[pc_model[7:0]];
        wait_left = pick_delay();
      end else begin
        mem_rdy  = 1'b0;
        mem_data = 8'($urandom);
        if (ctrl_signals[4] && !mem_stall) wait_left--;
      end

      if (ctrl_signals[0]) begin
        if (ctrl_signals[2]) pc_model[7:0]  = pc_data;
        if (ctrl_signals[1]) pc_model[15:8] = pc_data;
      end else if (ctrl_signals[2] && ctrl_signals[1]) begin
        pc_model = pc_model + 16'd1;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mon();
    n_fetch_inc = 0; n_op_inc = 0; n_valid = 0; n_memrd = 0; n_load = 0;
    post_load_ctrl = 5'd0;
    load_ctrl[0] = 5'd0; load_ctrl[1] = 5'd0;
    load_data[0] = 8'd0; load_data[1] = 8'd0;
  endtask

  task automatic wait_dispatch(input string tag);
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    check_eq({tag, "_dispatch_reached"}, 16'(cmd_ready), 16'h1);
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic c);
    repeat ($urandom_range(0, 2)) step();
    cmd_valid = 1'b1;
    cmd_type  = t;
    cond      = c;
    step();
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cond      = 1'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) step();
    check_eq("rst_ctrl", 16'(ctrl_signals), 16'h0);
    check_eq("rst_opcode", 16'(opcode), 16'h0);
    check_eq("rst_valid", 16'(opcode_valid), 16'h0);
    check_eq("rst_ready", 16'(cmd_ready), 16'h0);
    check_eq("rst_pc_data", 16'(pc_data), 16'h0);
    check_eq("rst_error", 16'(error), 16'h0);
    reset = 1'b0;
    exp_pc = 16'h0000;
  endtask

  task automatic start_fetch(input bit chk_rd, input int exp_rd);
    int k;
    logic [7:0] exp_op;
    exp_op = mem[0];
    clear_mon();
    run = 1'b1;
    k = 0;
    while (opcode_valid !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check_eq("first_valid", 16'(opcode_valid), 16'h1);
    check_eq("first_opcode", 16'(opcode), 16'(exp_op));
    check_eq("inc_ctrl", 16'(ctrl_signals), 16'h000E);
    if (chk_rd) check_eq("first_rd_cycles", 16'(n_memrd), 16'(exp_rd));
    step();
    check_eq("valid_one_cycle", 16'(opcode_valid), 16'h0);
    check_eq("dispatch_ready", 16'(cmd_ready), 16'h1);
    check_eq("dispatch_ctrl", 16'(ctrl_signals), 16'h0);
    check_eq("first_pc", pc_model, 16'h0001);
    exp_pc = 16'h0001;
  endtask

  task automatic place_ops();
    logic [15:0] pc1;
    pc1 = exp_pc + 16'd1;
    mem[exp_pc[7:0]] = 8'h34;
    mem[pc1[7:0]]    = 8'h12;
  endtask

  // Instruction-level reference: where the PC goes and what gets fetched.
  task automatic run_cmd(input logic [1:0] t, input logic c);
    logic [15:0] pc1, fetch_pc;
    logic [7:0]  lo, hi, exp_op;
    logic        taken;
    pc1   = exp_pc + 16'd1;
    lo    = mem[exp_pc[7:0]];
    hi    = mem[pc1[7:0]];
    taken = (t == C_JUMP) || (t == C_BRANCH && c);
    if (t == C_NEXT)  fetch_pc = exp_pc;
    else if (taken)   fetch_pc = {hi, lo};
    else              fetch_pc = exp_pc + 16'd2;
    exp_op = mem[fetch_pc[7:0]];
    exp_pc = fetch_pc + 16'd1;

    clear_mon();
    send_cmd(t, c);
    wait_dispatch("cmd");
    check_eq("opcode", 16'(opcode), 16'(exp_op));
    check_eq("pc", pc_model, exp_pc);
    check_eq("valid_pulses", 16'(n_valid), 16'h1);
    check_eq("fetch_incs", 16'(n_fetch_inc), 16'h1);
    check_eq("operand_incs", 16'(n_op_inc), (t == C_NEXT) ? 16'h0 : 16'h2);
    check_eq("load_cycles", 16'(n_load), taken ? 16'h2 : 16'h0);
    check_eq("no_error", 16'(error), 16'h0);
    if (taken) begin
      check_eq("lo_ctrl", 16'(load_ctrl[0]), 16'h0005);
      check_eq("lo_data", 16'(load_data[0]), 16'(lo));
      check_eq("hi_ctrl", 16'(load_ctrl[1]), 16'h0003);
      check_eq("hi_data", 16'(load_data[1]), 16'(hi));
      check_eq("post_load_memrd", 16'(post_load_ctrl), 16'h0010);
    end
  endtask

  task automatic halt_cmd();
    logic [7:0] exp_op;
    clear_mon();
    send_cmd(C_HALT, 1'b0);
    repeat (4) step();
    check_eq("halt_ready", 16'(cmd_ready), 16'h0);
    check_eq("halt_ctrl", 16'(ctrl_signals), 16'h0);
    check_eq("halt_no_fetch", 16'(n_memrd), 16'h0);
    run = 1'b0;
    repeat (2) step();
    check_eq("halt_run_low_ready", 16'(cmd_ready), 16'h0);
    run = 1'b1;
    exp_op = mem[exp_pc[7:0]];
    exp_pc = exp_pc + 16'd1;
    clear_mon();
    wait_dispatch("halt_exit");
    check_eq("halt_exit_opcode", 16'(opcode), 16'(exp_op));
    check_eq("halt_exit_pc", pc_model, exp_pc);
    check_eq("halt_exit_valid", 16'(n_valid), 16'h1);
  endtask

  initial begin
    int k;
    int r;
    exp_pc = 16'h0000;
    mem_stall = 1'b0;
    delay_mode = 2;
    clear_mon();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;

    // reset, idle hold, first fetch with a two-cycle memory latency
    do_reset();
    clear_mon();
    repeat (3) step();
    check_eq("idle_no_fetch", 16'(n_memrd), 16'h0);
    start_fetch(1'b1, 3);

    // directed jump / branch sequences with operands 34, 12
    delay_mode = -1;
    place_ops(); run_cmd(C_JUMP, 1'b0);
    place_ops(); run_cmd(C_BRANCH, 1'b0);
    place_ops(); run_cmd(C_BRANCH, 1'b1);
    halt_cmd();

    // randomized command stream
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      halt_cmd();
      else if (r < 4)  run_cmd(C_NEXT, 1'($urandom));
      else if (r < 7)  run_cmd(C_JUMP, 1'($urandom));
      else             run_cmd(C_BRANCH, 1'($urandom));
    end

    // memory timeout
    mem_stall = 1'b1;
    clear_mon();
    send_cmd(C_NEXT, 1'b0);
    k = 0;
    while (error !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    check_eq("timeout_error", 16'(error), 16'h1);
    check_eq("timeout_rd_cycles", 16'(n_memrd), 16'(TIMEOUT));
    check_eq("timeout_ctrl", 16'(ctrl_signals), 16'h0);
    check_eq("timeout_ready", 16'(cmd_ready), 16'h0);
    repeat (5) step();
    check_eq("timeout_sticky", 16'(error), 16'h1);
    check_eq("timeout_parked", 16'(ctrl_signals), 16'h0);
    mem_stall = 1'b0;

    // reset clears the sticky error; then abort a jump during LOAD_LO
    do_reset();
    start_fetch(1'b0, 0);
    place_ops();
    clear_mon();
    send_cmd(C_JUMP, 1'b0);
    k = 0;
    while (ctrl_signals !== 5'b00101 && k < 100) begin
      step();
      k++;
    end
    check_eq("load_lo_reached", 16'(ctrl_signals), 16'h0005);
    reset = 1'b1;
    #1;
    check_eq("abort_ctrl", 16'(ctrl_signals), 16'h0);
    check_eq("abort_pc_data", 16'(pc_data), 16'h0);
    check_eq("abort_opcode", 16'(opcode), 16'h0);
    check_eq("abort_ready", 16'(cmd_ready), 16'h0);
    check_eq("abort_valid", 16'(opcode_valid), 16'h0);
    step();
    reset = 1'b0;
    exp_pc = 16'h0000;
    start_fetch(1'b0, 0);
    run_cmd(C_NEXT, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
